osd_hex_field_scheduler: RTL
============================

# osd_hex_field_scheduler

Write-port master for the OSD debugger's `text_buffer`. It watches up to `NUM_FIELDS` live 8-bit debug values and writes each one into the character buffer as two uppercase ASCII hex digits. A field is rewritten only when its value has changed since its last write, or after a refresh request. The block replaces per-field hex writers, so only one source ever drives the buffer's single write port (`we`, `wr_addr`, `wr_data`). The renderer reads the buffer independently.

## Interface
- `NUM_FIELDS`, 4: number of watched values, 1..16.
- `ADDR_W`, 7: text buffer address width; the buffer holds 2^ADDR_W characters.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, no new field write is started.
- `force_refresh` in 1: single-cycle pulse; marks all fields for rewrite.
- `field_value` in NUM_FIELDS*8: value of field i is bits [8i+7:8i].
- `field_addr` in NUM_FIELDS*ADDR_W: buffer address of field i's high digit; its low digit goes at the next address.
- `wr_en` out 1: buffer write strobe; connects to `text_buffer.we`.
- `wr_addr` out ADDR_W: buffer write address.
- `wr_data` out 8: ASCII character to write.
- `busy` out 1: high while a two-character write is in progress.

## Operation
- State per field: `shadow[i]` (8 bits, last value written) and `valid[i]` (1 bit).
- Field i is dirty when `!valid[i] || field_value[i] != shadow[i]`.
- Scan pointer `ptr` visits fields in round-robin order, 0..NUM_FIELDS-1, then wraps to 0.
- FSM states: SCAN, WR_HI, WR_LO.
  - SCAN, `enable`=1, field `ptr` dirty: latch `lat_val` = field_value[ptr] and `lat_addr` = field_addr[ptr]; go to WR_HI.
  - SCAN, any other case: `ptr` advances by 1 (only while `enable`=1); stay in SCAN.
  - WR_HI: write hex(lat_val[7:4]) at `lat_addr`; go to WR_LO.
  - WR_LO: write hex(lat_val[3:0]) at `(lat_addr+1) mod 2^ADDR_W`; set `shadow[ptr]` = lat_val and `valid[ptr]` = 1; advance `ptr`; return to SCAN.
- Hex encoding: nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46 (uppercase only).
- The value is latched once per pair, so the two digits always come from the same sample. A change during WR_HI or WR_LO leaves the field dirty, and it is rewritten on a later pass.
- `force_refresh`: all `valid` bits are cleared in the same cycle. If it arrives during WR_LO, it overrides that state's `valid` set, so the in-progress field is also rewritten.
- Dropping `enable` never aborts a pair already started: WR_HI is always followed by WR_LO.

## Timing
- Every output is registered. Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0. Internal reset values: state=SCAN, `ptr`=0, all `shadow`=0, all `valid`=0.
- Write pulses come from the registered outputs, so `wr_en` is high in the cycle after the FSM enters WR_HI and the cycle after it enters WR_LO. The result is exactly two consecutive `wr_en` cycles per field, with `busy` high in the same two cycles.
- Cost of a clean field: 1 cycle in SCAN. Cost of a dirty field: 3 cycles (SCAN, WR_HI, WR_LO).
- Worst-case latency from a value change to its first `wr_en`: 3*NUM_FIELDS+1 cycles.
- After reset is released, every field is written once in index order. No further writes happen while the values are stable.
- Reset asserted mid-pair: outputs clear immediately (asynchronously), so a lone high-digit write may remain in the buffer. Because `valid` is cleared, that field is fully rewritten after reset.

## Test plan
- Initial fill: reset, then field_value = {FF,3C,A5,00}, field_addr = {127,72,40,8}, `enable`=1. Required: 8 `wr_en` pulses in order (8,'0'), (9,'0'), (40,'A'), (41,'5'), (72,'3'), (73,'C'), (127,'F'), and (0,'F') where the last address wraps. Then no `wr_en` for 100 cycles.
- Single change: set field 2 to 0x7E. Required: exactly (72,0x37) then (73,0x45), within 13 cycles. No other field is written.
- Change mid-write: change field 1 to 0x12 during its WR_HI. Required: the old pair completes with matching digits, followed by a second pair on a later pass (40,'1'), (41,'2').
- `force_refresh` pulse with stable values: required is a full rewrite of all 8 characters in index order, with identical data.
- `enable` low: hold `enable` low and change all values. Required: no `wr_en`. Dropping `enable` during WR_HI still yields the WR_LO write. Raising `enable` again produces all pending writes.
- Reset mid-pair: assert `reset` one cycle after the WR_HI write. Required: `wr_en`=0 and `busy`=0 asynchronously. After release, all four fields are rewritten starting with field 0.

Source files
------------

// File: rtl/osd_hex_field_scheduler.sv
// Single write-port master for the OSD text buffer: renders watched 8-bit values as two
// uppercase hex characters, rewriting a field only when it changed or after a refresh.
//
// state | meaning
// SCAN  | visit field ptr; start a pair if it is dirty, else advance ptr
// WR_HI | emit high-nibble character at lat_addr
// WR_LO | emit low-nibble character at lat_addr+1, record field as written
module osd_hex_field_scheduler #(
    parameter int NUM_FIELDS = 4,
    parameter int ADDR_W     = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       force_refresh,
    input  logic [NUM_FIELDS*8-1:0]    field_value,
    input  logic [NUM_FIELDS*ADDR_W-1:0] field_addr,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       busy
);

    localparam int PTR_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic [1:0] {SCAN, WR_HI, WR_LO} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt, ptr_inc;
    logic [7:0]         lat_val, lat_val_nxt;
    logic [ADDR_W-1:0]  lat_addr, lat_addr_nxt;
    logic [7:0]         shadow [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] valid;
    logic [7:0]         cur_val;
    logic [ADDR_W-1:0]  cur_addr;
    logic               cur_dirty;
    logic               commit;
    logic               out_en;
    logic [ADDR_W-1:0]  out_addr;
    logic [7:0]         out_data;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        cur_val   = '0;
        cur_addr  = '0;
        cur_dirty = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (ptr == PTR_W'(i)) begin
                cur_val   = field_value[i*8 +: 8];
                cur_addr  = field_addr[i*ADDR_W +: ADDR_W];
                cur_dirty = !valid[i] || (field_value[i*8 +: 8] != shadow[i]);
            end
        end
    end

    assign ptr_inc = (ptr == PTR_W'(NUM_FIELDS - 1)) ? '0 : ptr + 1'b1;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        lat_val_nxt  = lat_val;
        lat_addr_nxt = lat_addr;
        commit       = 1'b0;
        out_en       = 1'b0;
        out_addr     = '0;
        out_data     = '0;
        case (state)
            SCAN: begin
                if (enable) begin
                    if (cur_dirty) begin
                        lat_val_nxt  = cur_val;
                        lat_addr_nxt = cur_addr;
                        state_nxt    = WR_HI;
                    end else begin
                        ptr_nxt = ptr_inc;
                    end
                end
            end
            WR_HI: begin
                out_en    = 1'b1;
                out_addr  = lat_addr;
                out_data  = hex_char(lat_val[7:4]);
                state_nxt = WR_LO;
            end
            WR_LO: begin
                out_en    = 1'b1;
                out_addr  = lat_addr + 1'b1;
                out_data  = hex_char(lat_val[3:0]);
                commit    = 1'b1;
                ptr_nxt   = ptr_inc;
                state_nxt = SCAN;
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            ptr      <= '0;
            lat_val  <= '0;
            lat_addr <= '0;
            valid    <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) shadow[i] <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lat_val  <= lat_val_nxt;
            lat_addr <= lat_addr_nxt;
            wr_en    <= out_en;
            wr_addr  <= out_addr;
            wr_data  <= out_data;
            busy     <= out_en;
            if (commit) begin
                shadow[ptr] <= lat_val;
                valid[ptr]  <= 1'b1;
            end
            // A refresh in the same cycle as a commit wins, so that field is redone too.
            if (force_refresh) valid <= '0;
        end
    end

endmodule
